cp0_reg: RTL and testbench

- Coprocessor-0 register file; consumer of the MEM-stage exception decision.
- Commits exception side effects: EPC, Cause, Status.EXL, BadVAddr.
- Services MTC0/MFC0, runs the Count/Compare timer and latches external interrupt pending bits.
- Supplies Status/Cause/EPC/EBase back to exception detection, which closes the loop.

---
 rtl/cp0_reg_pkg.sv | 58 +++++
 rtl/cp0_reg_timer.sv | 50 +++++
 rtl/cp0_reg.sv | 135 +++++++++++++
 tb/tb_cp0_reg.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_reg_pkg.sv
// Shared CP0 definitions: exception codes, register numbers, field positions
// and MTC0 write masks.
package cp0_reg_pkg;

  localparam logic [4:0] EXC_CODE_INT   = 5'd0;
  localparam logic [4:0] EXC_CODE_MOD   = 5'd1;
  localparam logic [4:0] EXC_CODE_TLBL  = 5'd2;
  localparam logic [4:0] EXC_CODE_TLBS  = 5'd3;
  localparam logic [4:0] EXC_CODE_ADEL  = 5'd4;
  localparam logic [4:0] EXC_CODE_ADES  = 5'd5;
  localparam logic [4:0] EXC_CODE_SYS   = 5'd8;
  localparam logic [4:0] EXC_CODE_BP    = 5'd9;
  localparam logic [4:0] EXC_CODE_RI    = 5'd10;
  localparam logic [4:0] EXC_CODE_OV    = 5'd12;
  localparam logic [4:0] EXC_CODE_TR    = 5'd13;
  localparam logic [4:0] EXC_CODE_ERET  = 5'h1e;
  localparam logic [4:0] EXC_CODE_NOEXC = 5'h1f;

  localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_REG_EPC      = 5'd14;
  localparam logic [4:0] CP0_REG_PRID     = 5'd15;
  localparam logic [4:0] CP0_REG_EBASE    = 5'd15;
  localparam logic [4:0] CP0_REG_CONFIG   = 5'd16;

  localparam logic [2:0] CP0_SEL_EBASE = 3'd1;

  localparam int STATUS_BEV_BIT = 22;
  localparam int STATUS_EXL_BIT = 1;
  localparam int STATUS_IE_BIT  = 0;
  localparam int CAUSE_BD_BIT   = 31;
  localparam int CAUSE_IP_HI    = 15;
  localparam int CAUSE_IP_LO    = 8;
  localparam int CAUSE_EXC_HI   = 6;
  localparam int CAUSE_EXC_LO   = 2;

  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h0040_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
  localparam logic [31:0] EBASE_WMASK  = 32'h3FFF_F000;

  // Exceptions that report a faulting address through BadVAddr.
  function automatic logic is_addr_fault(input logic [4:0] code);
    return (code == EXC_CODE_ADEL) || (code == EXC_CODE_ADES) ||
           (code == EXC_CODE_TLBL) || (code == EXC_CODE_TLBS) ||
           (code == EXC_CODE_MOD);
  endfunction

  function automatic logic [31:0] masked_write(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/cp0_reg_timer.sv
// Count/Compare timer: Count advances every second cycle, a non-zero Compare
// match raises a sticky interrupt that only a Compare write clears.
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] data_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);

  logic        tick_q;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        timer_int_q, timer_int_d;

  always_comb begin
    count_d     = count_we_i ? data_i : count_q + {31'd0, tick_q};
    compare_d   = compare_we_i ? data_i : compare_q;
    timer_int_d = timer_int_q;
    if (compare_we_i) begin
      timer_int_d = 1'b0;
    end else if ((count_q == compare_q) && (compare_q != 32'd0)) begin
      timer_int_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q      <= 1'b0;
      count_q     <= 32'd0;
      compare_q   <= 32'd0;
      timer_int_q <= 1'b0;
    end else begin
      tick_q      <= ~tick_q;
      count_q     <= count_d;
      compare_q   <= compare_d;
      timer_int_q <= timer_int_d;
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign timer_int_o = timer_int_q;

endmodule

// File: rtl/cp0_reg.sv
// Coprocessor-0 register file: commits MEM-stage exceptions, services
// MTC0/MFC0 and feeds Status/Cause/EPC/EBase back to exception detection.
module cp0_reg
  import cp0_reg_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE   = 32'h0001_8000,
  parameter logic [31:0] CONFIG_VALUE = 32'h8000_0000,
  parameter logic [31:0] EBASE_RESET  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [2:0]  wsel_i,
  input  logic [4:0]  raddr_i,
  input  logic [2:0]  rsel_i,
  input  logic [31:0] data_i,
  input  logic [5:0]  int_i,
  input  logic [4:0]  except_type_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic [31:0] badvaddr_i,
  output logic [31:0] data_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] ebase_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] badvaddr_o,
  output logic        timer_int_o
);

  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] ebase_q, ebase_d;
  logic [31:0] badvaddr_q, badvaddr_d;

  logic is_eret, exc_commit, mtc0_en;
  logic wr_count, wr_compare, wr_status, wr_cause, wr_epc, wr_ebase;

  // Any exception or ERET flushes the writing instruction, so its MTC0 is dropped.
  assign is_eret    = (except_type_i == EXC_CODE_ERET);
  assign exc_commit = (except_type_i != EXC_CODE_NOEXC) && !is_eret;
  assign mtc0_en    = we_i && (except_type_i == EXC_CODE_NOEXC);

  assign wr_count   = mtc0_en && (waddr_i == CP0_REG_COUNT)   && (wsel_i == 3'd0);
  assign wr_compare = mtc0_en && (waddr_i == CP0_REG_COMPARE) && (wsel_i == 3'd0);
  assign wr_status  = mtc0_en && (waddr_i == CP0_REG_STATUS)  && (wsel_i == 3'd0);
  assign wr_cause   = mtc0_en && (waddr_i == CP0_REG_CAUSE)   && (wsel_i == 3'd0);
  assign wr_epc     = mtc0_en && (waddr_i == CP0_REG_EPC)     && (wsel_i == 3'd0);
  assign wr_ebase   = mtc0_en && (waddr_i == CP0_REG_EBASE)   && (wsel_i == CP0_SEL_EBASE);

  cp0_timer u_timer (
    .clk          (clk),
    .rst          (rst),
    .count_we_i   (wr_count),
    .compare_we_i (wr_compare),
    .data_i       (data_i),
    .count_o      (count_o),
    .compare_o    (compare_o),
    .timer_int_o  (timer_int_o)
  );

  // NOTE: each next-state value starts from its current register so no path
  // through the block leaves it unassigned, which would infer a latch.
  always_comb begin
    status_d   = status_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    ebase_d    = ebase_q;
    badvaddr_d = badvaddr_q;

    cause_d[CAUSE_IP_HI:CAUSE_IP_LO+2] = {int_i[5] | timer_int_o, int_i[4:0]};

    if (wr_status) status_d = masked_write(status_q, data_i, STATUS_WMASK);
    if (wr_cause)  cause_d  = masked_write(cause_d, data_i, CAUSE_WMASK);
    if (wr_epc)    epc_d    = data_i;
    if (wr_ebase)  ebase_d  = masked_write(ebase_q, data_i, EBASE_WMASK);

    if (exc_commit) begin
      // A nested exception keeps the original return point.
      if (!status_q[STATUS_EXL_BIT]) begin
        epc_d                 = in_delayslot_i ? pc_i - 32'd4 : pc_i;
        cause_d[CAUSE_BD_BIT] = in_delayslot_i;
      end
      status_d[STATUS_EXL_BIT]         = 1'b1;
      cause_d[CAUSE_EXC_HI:CAUSE_EXC_LO] = except_type_i;
      if (is_addr_fault(except_type_i)) badvaddr_d = badvaddr_i;
    end else if (is_eret) begin
      status_d[STATUS_EXL_BIT] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q   <= STATUS_RESET;
      cause_q    <= 32'd0;
      epc_q      <= 32'd0;
      ebase_q    <= EBASE_RESET;
      badvaddr_q <= 32'd0;
    end else begin
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      ebase_q    <= ebase_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  // Registered values only; the pipeline resolves MTC0->MFC0 hazards.
  always_comb begin
    data_o = 32'd0;
    unique case ({raddr_i, rsel_i})
      {CP0_REG_BADVADDR, 3'd0}:        data_o = badvaddr_q;
      {CP0_REG_COUNT, 3'd0}:           data_o = count_o;
      {CP0_REG_COMPARE, 3'd0}:         data_o = compare_o;
      {CP0_REG_STATUS, 3'd0}:          data_o = status_q;
      {CP0_REG_CAUSE, 3'd0}:           data_o = cause_q;
      {CP0_REG_EPC, 3'd0}:             data_o = epc_q;
      {CP0_REG_PRID, 3'd0}:            data_o = PRID_VALUE;
      {CP0_REG_EBASE, CP0_SEL_EBASE}:  data_o = ebase_q;
      {CP0_REG_CONFIG, 3'd0}:          data_o = CONFIG_VALUE;
      default:                         data_o = 32'd0;
    endcase
  end

  assign status_o   = status_q;
  assign cause_o    = cause_q;
  assign epc_o      = epc_q;
  assign ebase_o    = ebase_q;
  assign badvaddr_o = badvaddr_q;

endmodule

// File: tb/tb_cp0_reg.sv
// Scoreboard bench for cp0_reg: expectations are queued with each stimulus
// step and drained against the DUT outputs one time unit after the edge.
module tb_cp0_reg;
  import cp0_reg_pkg::*;

  typedef enum logic [3:0] {
    O_STATUS, O_CAUSE, O_EPC, O_EBASE, O_COUNT, O_COMPARE, O_BADV, O_TINT, O_DATA
  } obs_e;

  typedef struct {
    string       tag;
    obs_e        sel;
    logic [31:0] exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we_i = 1'b0;
  logic [4:0]  waddr_i = '0;
  logic [2:0]  wsel_i = '0;
  logic [4:0]  raddr_i = '0;
  logic [2:0]  rsel_i = '0;
  logic [31:0] data_i = '0;
  logic [5:0]  int_i = '0;
  logic [4:0]  except_type_i = EXC_CODE_NOEXC;
  logic [31:0] pc_i = '0;
  logic        in_delayslot_i = 1'b0;
  logic [31:0] badvaddr_i = '0;
  logic [31:0] data_o, status_o, cause_o, epc_o, ebase_o, count_o, compare_o, badvaddr_o;
  logic        timer_int_o;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  cp0_reg dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .wsel_i(wsel_i),
    .raddr_i(raddr_i), .rsel_i(rsel_i), .data_i(data_i), .int_i(int_i),
    .except_type_i(except_type_i), .pc_i(pc_i), .in_delayslot_i(in_delayslot_i),
    .badvaddr_i(badvaddr_i), .data_o(data_o), .status_o(status_o),
    .cause_o(cause_o), .epc_o(epc_o), .ebase_o(ebase_o), .count_o(count_o),
    .compare_o(compare_o), .badvaddr_o(badvaddr_o), .timer_int_o(timer_int_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input obs_e sel);
    case (sel)
      O_STATUS:  return status_o;
      O_CAUSE:   return cause_o;
      O_EPC:     return epc_o;
      O_EBASE:   return ebase_o;
      O_COUNT:   return count_o;
      O_COMPARE: return compare_o;
      O_BADV:    return badvaddr_o;
      O_TINT:    return {31'd0, timer_int_o};
      default:   return data_o;
    endcase
  endfunction

  task automatic expect_out(input obs_e sel, input logic [31:0] exp, input string tag);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] r, input logic [2:0] s, input logic [31:0] d);
    we_i = 1'b1; waddr_i = r; wsel_i = s; data_i = d;
    cycle();
    we_i = 1'b0;
  endtask

  task automatic mfc0(input logic [4:0] r, input logic [2:0] s);
    raddr_i = r; rsel_i = s;
    #1;
  endtask

  task automatic raise(input logic [4:0] code, input logic [31:0] pc, input logic ds,
                       input logic [31:0] badv);
    except_type_i = code; pc_i = pc; in_delayslot_i = ds; badvaddr_i = badv;
    cycle();
    except_type_i = EXC_CODE_NOEXC; in_delayslot_i = 1'b0;
  endtask

  initial begin
    int waited;

    // Reset values while reset is held.
    cycle(); cycle();
    expect_out(O_STATUS, 32'h0040_0000, "rst_status");
    expect_out(O_EBASE, 32'h8000_0000, "rst_ebase");
    expect_out(O_CAUSE, 32'h0, "rst_cause");
    expect_out(O_EPC, 32'h0, "rst_epc");
    expect_out(O_COUNT, 32'h0, "rst_count");
    expect_out(O_COMPARE, 32'h0, "rst_compare");
    expect_out(O_BADV, 32'h0, "rst_badv");
    expect_out(O_TINT, 32'h0, "rst_tint");
    drain();
    rst = 1'b0;
    cycle();

    // Status write mask and MFC0 of the written value.
    mtc0(CP0_REG_STATUS, 3'd0, 32'hFFFF_FFFF);
    mfc0(CP0_REG_STATUS, 3'd0);
    expect_out(O_STATUS, 32'h0040_FF03, "status_mask");
    expect_out(O_DATA, 32'h0040_FF03, "mfc0_status");
    drain();

    // Cause only takes IP1:0 from software.
    mtc0(CP0_REG_CAUSE, 3'd0, 32'hFFFF_FFFF);
    expect_out(O_CAUSE, 32'h0000_0300, "cause_mask");
    drain();

    // Read-only and constant registers, unmapped write ignored.
    mtc0(5'd3, 3'd0, 32'hDEAD_BEEF);
    mfc0(5'd3, 3'd0);
    expect_out(O_DATA, 32'h0, "unmapped_rd");
    drain();
    mfc0(CP0_REG_PRID, 3'd0);
    expect_out(O_DATA, 32'h0001_8000, "prid");
    drain();
    mfc0(CP0_REG_CONFIG, 3'd0);
    expect_out(O_DATA, 32'h8000_0000, "config");
    drain();
    mtc0(CP0_REG_EBASE, CP0_SEL_EBASE, 32'hFFFF_FFFF);
    mfc0(CP0_REG_EBASE, CP0_SEL_EBASE);
    expect_out(O_EBASE, 32'hBFFF_F000, "ebase_mask");
    expect_out(O_DATA, 32'hBFFF_F000, "mfc0_ebase");
    drain();

    // Clear EXL and BEV before the first exception.
    mtc0(CP0_REG_STATUS, 3'd0, 32'h0000_FF01);
    expect_out(O_STATUS, 32'h0000_FF01, "status_clr_exl");
    drain();

    // SYS in a delay slot with EXL=0.
    raise(EXC_CODE_SYS, 32'hBFC0_0100, 1'b1, 32'h0);
    expect_out(O_EPC, 32'hBFC0_00FC, "sys_epc");
    expect_out(O_CAUSE, 32'h8000_0320, "sys_cause");
    expect_out(O_STATUS, 32'h0000_FF03, "sys_status");
    drain();

    // Nested ADEL: EPC and BD hold, BadVAddr captured.
    raise(EXC_CODE_ADEL, 32'h8000_0040, 1'b0, 32'h0000_0003);
    mfc0(CP0_REG_BADVADDR, 3'd0);
    expect_out(O_EPC, 32'hBFC0_00FC, "adel_epc");
    expect_out(O_CAUSE, 32'h8000_0310, "adel_cause");
    expect_out(O_BADV, 32'h0000_0003, "adel_badv");
    expect_out(O_DATA, 32'h0000_0003, "mfc0_badv");
    drain();

    raise(EXC_CODE_ERET, 32'h0, 1'b0, 32'h0);
    expect_out(O_STATUS, 32'h0000_FF01, "eret_status");
    expect_out(O_EPC, 32'hBFC0_00FC, "eret_epc");
    drain();

    // Count load beats the increment.
    mtc0(CP0_REG_COUNT, 3'd0, 32'h1234_5678);
    expect_out(O_COUNT, 32'h1234_5678, "count_load");
    drain();

    // Timer: Count from 0 up to Compare=5.
    mtc0(CP0_REG_COUNT, 3'd0, 32'h0);
    mtc0(CP0_REG_COMPARE, 3'd0, 32'd5);
    expect_out(O_TINT, 32'h0, "tint_before");
    drain();
    waited = 0;
    while (!timer_int_o && waited < 40) begin
      cycle();
      waited++;
    end
    expect_out(O_TINT, 32'h1, "tint_rise");
    expect_out(O_COUNT, 32'd5, "tint_count");
    drain();
    cycle();
    expect_out(O_CAUSE, 32'h8000_8310, "tint_ip7");
    expect_out(O_TINT, 32'h1, "tint_sticky");
    drain();
    mtc0(CP0_REG_COMPARE, 3'd0, 32'd100);
    expect_out(O_TINT, 32'h0, "tint_clear");
    expect_out(O_COMPARE, 32'd100, "compare_100");
    drain();

    // MTC0 to EPC discarded by a simultaneous OV exception.
    we_i = 1'b1; waddr_i = CP0_REG_EPC; wsel_i = 3'd0; data_i = 32'h0000_1234;
    raise(EXC_CODE_OV, 32'h8000_0200, 1'b0, 32'h0);
    we_i = 1'b0;
    expect_out(O_EPC, 32'h8000_0200, "ov_epc");
    expect_out(O_CAUSE, 32'h0000_0330, "ov_cause");
    expect_out(O_STATUS, 32'h0000_FF03, "ov_status");
    drain();

    // External interrupt lines sampled into IP7/IP2.
    int_i = 6'b100001;
    cycle();
    expect_out(O_CAUSE, 32'h0000_8730, "hw_int_ip");
    drain();
    int_i = 6'b000000;
    cycle();
    expect_out(O_CAUSE, 32'h0000_0330, "hw_int_clr");
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
